// File: rtl/spi_slave_responder_if.sv
// SPI link pins, mode controls and local tx/rx handshake for spi_slave_responder.
interface spi_slave_responder_if #(
  parameter int DW = 32
);
  logic          sclk;
  logic          ss_n;
  logic          mosi;
  logic          miso;
  logic          miso_oe;
  logic          cpol;
  logic          cpha;
  logic          lsb_first;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          tx_underrun;
  logic          busy;

  modport master (
    output sclk, ss_n, mosi, cpol, cpha, lsb_first, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport slave (
    input  sclk, ss_n, mosi, cpol, cpha, lsb_first, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI slave endpoint, modes 0-3: oversampled pins, one-word tx holding register,
// received words presented as a one-cycle rx_valid pulse.
module spi_slave_responder #(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_slave_responder_if.slave bus
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;

  logic [2:0]    sclk_s;
  logic [2:0]    ss_s;
  logic [1:0]    mosi_s;
  logic [DW-1:0] hold_data;
  logic          hold_full;
  logic [DW-1:0] tx_sr;
  logic [DW-1:0] rx_sr;
  logic [DW-1:0] rx_nx;
  logic [DW-1:0] rx_data_r;
  logic          rx_valid_r;
  logic [CW-1:0] cnt;
  logic          skip_drive;
  logic          reload_pend;

  logic ss_fall, ss_rise, lead, trail, sample_edge, drive_edge;
  logic load, clr, shift_tx, sample, skip_clr;

  // ss_n sync resets low so a frame already active at reset release never
  // produces a falling edge; the master must raise ss_n first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      ss_s   <= '0;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], bus.sclk};
      ss_s   <= {ss_s[1:0], bus.ss_n};
      mosi_s <= {mosi_s[0], bus.mosi};
    end
  end

  assign ss_fall     = !ss_s[1] && ss_s[2];
  assign ss_rise     = ss_s[1] && !ss_s[2];
  assign lead        = (sclk_s[1] != bus.cpol) && (sclk_s[2] == bus.cpol);
  assign trail       = (sclk_s[1] == bus.cpol) && (sclk_s[2] != bus.cpol);
  assign sample_edge = bus.cpha ? trail : lead;
  assign drive_edge  = bus.cpha ? lead : trail;
  assign rx_nx       = bus.lsb_first ? {mosi_s[1], rx_sr[DW-1:1]}
                                     : {rx_sr[DW-2:0], mosi_s[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ss_fall) state_nx = ACTIVE;
      ACTIVE:  if (ss_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // cpha=1 reloads in the completion cycle (rx_valid_r high); cpha=0 reloads
  // on the drive edge that would otherwise shift past the last bit.
  always_comb begin
    load     = 1'b0;
    clr      = 1'b0;
    shift_tx = 1'b0;
    sample   = 1'b0;
    skip_clr = 1'b0;
    case (state)
      IDLE: load = ss_fall;
      ACTIVE: begin
        if (ss_rise) begin
          clr = 1'b1;
        end else begin
          sample = sample_edge;
          if (bus.cpha) begin
            load = rx_valid_r;
            if (drive_edge) begin
              if (skip_drive) skip_clr = 1'b1;
              else            shift_tx = 1'b1;
            end
          end else if (drive_edge) begin
            if (reload_pend) load     = 1'b1;
            else             shift_tx = 1'b1;
          end
        end
      end
      default: ;
    endcase
    bus.busy        = (state == ACTIVE);
    bus.miso_oe     = (state == ACTIVE);
    bus.miso        = (state == ACTIVE) && (bus.lsb_first ? tx_sr[0] : tx_sr[DW-1]);
    bus.tx_underrun = load && !hold_full;
    bus.tx_ready    = !hold_full;
    bus.rx_data     = rx_data_r;
    bus.rx_valid    = rx_valid_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data   <= '0;
      hold_full   <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      cnt         <= '0;
      skip_drive  <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      // A reload consumes the registered holding state, so a same-cycle
      // handshake lands in the holding register for the following word.
      if (load && hold_full) begin
        hold_full <= 1'b0;
      end else if (bus.tx_valid && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= bus.tx_data;
      end

      if (clr) begin
        tx_sr       <= '0;
        skip_drive  <= 1'b0;
        reload_pend <= 1'b0;
      end else if (load) begin
        tx_sr       <= hold_full ? hold_data : '0;
        skip_drive  <= bus.cpha;
        reload_pend <= 1'b0;
      end else begin
        if (shift_tx)
          tx_sr <= bus.lsb_first ? {1'b0, tx_sr[DW-1:1]} : {tx_sr[DW-2:0], 1'b0};
        if (skip_clr) skip_drive <= 1'b0;
      end

      rx_valid_r <= 1'b0;
      if (clr || (state == IDLE && ss_fall)) begin
        cnt <= '0;
      end else if (sample) begin
        rx_sr <= rx_nx;
        if (cnt == CW'(DW - 1)) begin
          cnt         <= '0;
          rx_data_r   <= rx_nx;
          rx_valid_r  <= 1'b1;
          reload_pend <= !bus.cpha;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: bus-functional SPI master plus
// hand-computed expected words for each mode, bit order and frame scenario.
module tb_spi_slave_responder;
  localparam int DW = 32;
  localparam int H  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_responder_if #(.DW(DW)) bus ();
  spi_slave_responder #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          rv_cnt = 0;
  int          ur_cnt = 0;
  logic [31:0] rx_hist[$];

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rv_cnt++;
      rx_hist.push_back(bus.rx_data);
    end
    if (bus.tx_underrun === 1'b1) ur_cnt++;
  end

  task automatic push_tx(input logic [31:0] d);
    int n;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 64'(bus.tx_ready), 64'd1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic lsb);
    bus.cpol      = pol;
    bus.cpha      = pha;
    bus.lsb_first = lsb;
    bus.sclk      = pol;
    repeat (H) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [31:0] mo, input int nbits, output logic [31:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = bus.lsb_first ? i : DW - 1 - i;
      if (!bus.cpha) begin
        bus.mosi = mo[b];
        repeat (H) @(negedge clk);
        mi[b]    = bus.miso;
        bus.sclk = ~bus.cpol;
        repeat (H) @(negedge clk);
        bus.sclk = bus.cpol;
      end else begin
        repeat (H) @(negedge clk);
        bus.sclk = ~bus.cpol;
        bus.mosi = mo[b];
        repeat (H) @(negedge clk);
        mi[b]    = bus.miso;
        bus.sclk = bus.cpol;
      end
    end
  endtask

  task automatic end_frame();
    repeat (H) @(negedge clk);
    bus.ss_n = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] mo, input int nbits, output logic [31:0] mi);
    bus.ss_n = 1'b0;
    spi_bits(mo, nbits, mi);
    end_frame();
  endtask

  logic [31:0] mi, mi2;
  logic [31:0] prev_rx;
  int          rv0, ur0;

  initial begin
    bus.sclk = 1'b0; bus.ss_n = 1'b1; bus.mosi = 1'b0;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsb_first = 1'b0;
    bus.tx_data = '0; bus.tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // reset state: {busy, miso_oe, miso, rx_valid, tx_underrun, tx_ready}
    check("rst_outs", 64'({bus.busy, bus.miso_oe, bus.miso, bus.rx_valid, bus.tx_underrun, bus.tx_ready}), 64'b000001);
    check("rst_rx_data", 64'(bus.rx_data), 64'd0);

    // mode 0, MSB first
    push_tx(32'hA5A5_0F0F);
    check("t1_ready_low", 64'(bus.tx_ready), 64'd0);
    rv0 = rv_cnt;
    bus.ss_n = 1'b0;
    repeat (6) @(negedge clk);
    check("t1_ready_at_ss", 64'(bus.tx_ready), 64'd1);
    check("t1_busy_oe", 64'({bus.busy, bus.miso_oe}), 64'b11);
    spi_bits(32'h1234_5678, 32, mi);
    end_frame();
    check("t1_rx_pulses", 64'(rv_cnt - rv0), 64'd1);
    check("t1_rx_data", 64'(bus.rx_data), 64'h1234_5678);
    check("t1_master_rx", 64'(mi), 64'hA5A5_0F0F);
    check("t1_idle_outs", 64'({bus.busy, bus.miso_oe, bus.miso}), 64'b000);

    // remaining mode / bit-order combinations
    for (int m = 1; m < 8; m++) begin
      logic [2:0] cfg;
      cfg = 3'(m);
      set_mode(cfg[1], cfg[0], cfg[2]);
      push_tx(32'hA5A5_0F0F);
      rv0 = rv_cnt;
      frame(32'h1234_5678, 32, mi);
      check($sformatf("mode%0d_lsb%0d_rx", cfg[1:0], cfg[2]), 64'(rx_hist[$]), 64'h1234_5678);
      check($sformatf("mode%0d_lsb%0d_mi", cfg[1:0], cfg[2]), 64'(mi), 64'hA5A5_0F0F);
      check($sformatf("mode%0d_lsb%0d_pulses", cfg[1:0], cfg[2]), 64'(rv_cnt - rv0), 64'd1);
    end

    // back-to-back words with ss_n held low; a filler word keeps the final reload fed
    set_mode(1'b0, 1'b0, 1'b0);
    push_tx(32'h1111_1111);
    rv0 = rv_cnt;
    ur0 = ur_cnt;
    bus.ss_n = 1'b0;
    fork
      begin
        spi_bits(32'hAAAA_5555, 32, mi);
        spi_bits(32'h0F0F_F0F0, 32, mi2);
      end
      begin
        push_tx(32'h2222_2222);
        push_tx(32'h3333_3333);
      end
    join
    end_frame();
    check("b2b_pulses", 64'(rv_cnt - rv0), 64'd2);
    check("b2b_rx0", 64'(rx_hist[rx_hist.size() - 2]), 64'hAAAA_5555);
    check("b2b_rx1", 64'(rx_hist[rx_hist.size() - 1]), 64'h0F0F_F0F0);
    check("b2b_mi0", 64'(mi), 64'h1111_1111);
    check("b2b_mi1", 64'(mi2), 64'h2222_2222);
    check("b2b_underrun", 64'(ur_cnt - ur0), 64'd0);

    // empty holding register; the end-of-word reload afterwards also underruns
    check("ur_hold_empty", 64'(bus.tx_ready), 64'd1);
    ur0 = ur_cnt;
    bus.ss_n = 1'b0;
    spi_bits(32'hC3C3_3C3C, 32, mi);
    check("ur_pulse_once", 64'(ur_cnt - ur0), 64'd1);
    end_frame();
    check("ur_miso_zero", 64'(mi), 64'd0);
    check("ur_rx_data", 64'(bus.rx_data), 64'hC3C3_3C3C);

    // partial frame of 13 bits is discarded
    prev_rx = bus.rx_data;
    rv0 = rv_cnt;
    frame(32'hFFFF_FFFF, 13, mi);
    check("part_no_pulse", 64'(rv_cnt - rv0), 64'd0);
    check("part_rx_kept", 64'(bus.rx_data), 64'(prev_rx));
    push_tx(32'h5A5A_C3C3);
    frame(32'h8765_4321, 32, mi);
    check("part_next_rx", 64'(bus.rx_data), 64'h8765_4321);
    check("part_next_mi", 64'(mi), 64'h5A5A_C3C3);

    // reset at bit 20, remaining edges ignored
    push_tx(32'hA5A5_0F0F);
    rv0 = rv_cnt;
    bus.ss_n = 1'b0;
    spi_bits(32'h1234_5678, 20, mi);
    rst_n = 1'b0;
    #1;
    check("mrst_outs", 64'({bus.busy, bus.miso_oe, bus.miso, bus.rx_valid, bus.tx_underrun, bus.tx_ready}), 64'b000001);
    check("mrst_rx_data", 64'(bus.rx_data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spi_bits(32'h1234_5678, 12, mi);
    repeat (H) @(negedge clk);
    check("mrst_ignored", 64'({bus.busy, bus.miso_oe}), 64'b00);
    check("mrst_no_pulse", 64'(rv_cnt - rv0), 64'd0);
    check("mrst_rx_zero", 64'(bus.rx_data), 64'd0);
    bus.ss_n = 1'b1;
    repeat (2 * H) @(negedge clk);
    push_tx(32'hA5A5_0F0F);
    frame(32'h1234_5678, 32, mi);
    check("mrst_next_rx", 64'(bus.rx_data), 64'h1234_5678);
    check("mrst_next_mi", 64'(mi), 64'hA5A5_0F0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
